// File: rtl/radar_pkg.sv
// Shared definitions for the Ka radar I/Q receive path.
//   - Default widths for the coherent integrator (sample, accumulator, bins).
//   - Integrator state enumeration.
//   - Generic two's-complement sign-extension helper (widths up to SEXT_MAX_W).
package radar_pkg;

  localparam int RADAR_IN_W = 16;
  localparam int RADAR_LEN  = 32;
  localparam int RADAR_NBIN = 256;

  // Widest value the sign-extension helper handles; LEN must not exceed it.
  localparam int SEXT_MAX_W = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Sign-extends the low w bits of x to SEXT_MAX_W bits. Callers zero-extend
  // their operand into x and truncate the result to the width they need.
  function automatic logic [SEXT_MAX_W-1:0] sign_ext(input logic [SEXT_MAX_W-1:0] x,
                                                     input int w);
    logic [SEXT_MAX_W-1:0] hi_mask;
    logic                  sign;
    hi_mask = {SEXT_MAX_W{1'b1}} << w;
    sign    = |(x & (64'd1 << (w - 1)));
    return sign ? (x | hi_mask) : (x & ~hi_mask);
  endfunction

endpackage

// File: rtl/accum_ram.sv
// Bin buffer for the coherent integrator.
// Simple dual-port RAM, DEPTH x DW: one synchronous write port and one read
// port with a registered output (one cycle read latency). No reset, so it
// maps onto block RAM.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled every clock
//   rdata  : registered read data for the address presented last cycle
module accum_ram #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset on purpose; a reset
  // would force the tools to build the buffer from flops instead of block RAM.
  // Chirp 0 always overwrites a bin before any later chirp reads it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/coherent_accum.sv
// Coherent multi-chirp integrator.
// Sums complex samples bin-by-bin over acc_num consecutive chirps using a
// read-modify-write bin buffer; on the final chirp of each integration the
// full-width sums are streamed out with out_valid (2-cycle latency).
//   clk, rst_n            : clock, asynchronous active-low reset
//   data_i, data_q        : I/Q input samples (two's complement, IN_W)
//   in_valid              : sample strobe
//   chirp_start           : sample is bin 0 of a chirp (qualified by in_valid)
//   acc_num               : chirps per integration (0 means 1), latched at chirp 0
//   data_out_i, data_out_q: accumulated I/Q (LEN)
//   out_valid, out_last   : output strobe, high on bin NBIN-1
//   frame_err             : sticky chirp-length error, cleared only by reset
module coherent_accum
  import radar_pkg::*;
#(
  parameter int IN_W = RADAR_IN_W,
  parameter int LEN  = RADAR_LEN,
  parameter int NBIN = RADAR_NBIN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] data_i,
  input  logic [IN_W-1:0] data_q,
  input  logic            in_valid,
  input  logic            chirp_start,
  input  logic [7:0]      acc_num,
  output logic [LEN-1:0]  data_out_i,
  output logic [LEN-1:0]  data_out_q,
  output logic            out_valid,
  output logic            out_last,
  output logic            frame_err
);

  localparam int AW = $clog2(NBIN);

  // ---------------------------------------------------------------------
  // Front end: FSM, counters and sample acceptance
  // ---------------------------------------------------------------------
  state_t          state, state_nxt;
  logic [AW-1:0]   bin_cnt, bin_nxt;
  logic [7:0]      chirp_cnt, chirp_nxt;
  logic [7:0]      acc_num_l, num_nxt;
  logic            err_nxt;
  logic            accept;
  logic [AW-1:0]   acc_bin;
  logic            acc_first;
  logic            acc_final;
  logic [7:0]      acc_num_eff;

  assign acc_num_eff = (acc_num == 8'd0) ? 8'd1 : acc_num;

  // NOTE: combinational blocks assign every output a default first so that
  // no path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_cnt;
    chirp_nxt = chirp_cnt;
    num_nxt   = acc_num_l;
    err_nxt   = frame_err;
    accept    = 1'b0;
    acc_bin   = bin_cnt;

    if (in_valid) begin
      case (state)
        IDLE: begin
          if (chirp_start) begin
            state_nxt = ACCUM;
            chirp_nxt = 8'd0;
            num_nxt   = acc_num_eff;
            acc_bin   = '0;
            accept    = 1'b1;
          end
        end
        ACCUM: begin
          // bin_cnt == 0 in ACCUM means the previous chirp is complete and
          // the next sample must carry chirp_start.
          if (chirp_start) begin
            accept  = 1'b1;
            acc_bin = '0;
            if (bin_cnt != '0) begin
              // Short chirp: flag and restart the integration here.
              err_nxt   = 1'b1;
              chirp_nxt = 8'd0;
              num_nxt   = acc_num_eff;
            end else if (chirp_cnt == acc_num_l - 8'd1) begin
              chirp_nxt = 8'd0;
              num_nxt   = acc_num_eff;
            end else begin
              chirp_nxt = chirp_cnt + 8'd1;
            end
          end else if (bin_cnt == '0) begin
            // Overlong chirp: sample dropped.
            err_nxt = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (accept) begin
      bin_nxt = acc_bin + 1'b1;
    end
  end

  assign acc_first = (chirp_nxt == 8'd0);
  assign acc_final = (chirp_nxt == num_nxt - 8'd1);

  // NOTE: every clocked block uses non-blocking assignments only, so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      chirp_cnt <= 8'd0;
      acc_num_l <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin_cnt   <= bin_nxt;
      chirp_cnt <= chirp_nxt;
      acc_num_l <= num_nxt;
      frame_err <= err_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // S1: register sample and control; buffer read issued on the same edge
  // ---------------------------------------------------------------------
  logic [LEN-1:0]  sext_i, sext_q;
  logic            s1_valid, s1_first, s1_final;
  logic [AW-1:0]   s1_bin;
  logic [LEN-1:0]  s1_i, s1_q;

  assign sext_i = LEN'(sign_ext(SEXT_MAX_W'(data_i), IN_W));
  assign sext_q = LEN'(sign_ext(SEXT_MAX_W'(data_q), IN_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_final <= 1'b0;
      s1_bin   <= '0;
      s1_i     <= '0;
      s1_q     <= '0;
    end else begin
      s1_valid <= accept;
      s1_first <= acc_first;
      s1_final <= acc_final;
      s1_bin   <= acc_bin;
      s1_i     <= sext_i;
      s1_q     <= sext_q;
    end
  end

  // ---------------------------------------------------------------------
  // S2: add against the buffered partial sum (chirp 0 ignores the read)
  // ---------------------------------------------------------------------
  logic [2*LEN-1:0] rd_word;
  logic [LEN-1:0]   rd_i, rd_q;
  logic             s2_valid, s2_final;
  logic [AW-1:0]    s2_bin;
  logic [LEN-1:0]   s2_sum_i, s2_sum_q;
  logic             ram_we;

  assign rd_i = rd_word[2*LEN-1:LEN];
  assign rd_q = rd_word[LEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_final <= 1'b0;
      s2_bin   <= '0;
      s2_sum_i <= '0;
      s2_sum_q <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_final <= s1_final;
      s2_bin   <= s1_bin;
      s2_sum_i <= s1_first ? s1_i : (rd_i + s1_i);
      s2_sum_q <= s1_first ? s1_q : (rd_q + s1_q);
    end
  end

  // The final chirp's sum leaves on the output and is not written back.
  // The write of bin b never collides with a read: the next read of b is a
  // full chirp (>= 4 samples) later.
  assign ram_we = s2_valid & ~s2_final;

  accum_ram #(
    .AW (AW),
    .DW (2 * LEN)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (s2_bin),
    .wdata ({s2_sum_i, s2_sum_q}),
    .raddr (acc_bin),
    .rdata (rd_word)
  );

  // ---------------------------------------------------------------------
  // Output registers (edge t+2)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      data_out_i <= '0;
      data_out_q <= '0;
    end else begin
      out_valid <= s2_valid & s2_final;
      out_last  <= s2_valid & s2_final & (s2_bin == AW'(NBIN - 1));
      if (s2_valid & s2_final) begin
        data_out_i <= s2_sum_i;
        data_out_q <= s2_sum_q;
      end
    end
  end

endmodule

// File: doc/coherent_accum.md
# coherent_accum

Coherent multi-chirp integrator for the Ka radar I/Q receive path, sitting directly upstream of the 32-bit-to-16-bit cut/saturate stage. It sums complex samples bin-by-bin across a programmable number of consecutive chirps, using an on-chip bin buffer with read-modify-write. On the final chirp of each integration it streams the full-width sums downstream with a valid strobe.

## Interface
- `IN_W`, 16: input sample width, two's complement.
- `LEN`, 32: accumulator and output width. Must satisfy LEN ≥ IN_W + 8.
- `NBIN`, 256: range bins per chirp, power of two, ≥ 4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_i` in IN_W: I sample.
- `data_q` in IN_W: Q sample.
- `in_valid` in 1: sample strobe.
- `chirp_start` in 1: marks the sample as bin 0 of a chirp. Sampled only when in_valid=1.
- `acc_num` in 8: chirps per integration. Value 0 is treated as 1. Latched at each chirp-0 start.
- `data_out_i` out LEN: accumulated I.
- `data_out_q` out LEN: accumulated Q.
- `out_valid` out 1: output strobe. Drives the next stage's in_valid.
- `out_last` out 1: high together with out_valid on bin NBIN-1.
- `frame_err` out 1: sticky chirp-length error. Cleared only by reset.

## Operation
- States:
  - IDLE: after reset. Waits for in_valid & chirp_start; that sample becomes chirp 0, bin 0, and the state goes to ACCUM.
  - ACCUM: counts chirps. Stays in ACCUM across chirps.
  - Samples arriving in IDLE without chirp_start are dropped.
- Counters:
  - bin_cnt (log2 NBIN bits): set to 0 on chirp_start, incremented per accepted sample.
  - chirp_cnt (8 bits): 0 … acc_num_l-1.
- Chirp 0: writes the sign-extended input to buffer[bin]. No read is used.
- Chirps 1 … acc_num_l-1: buffer[bin] ← buffer[bin] + sign_ext(sample), for I and Q independently.
- Final chirp (chirp_cnt = acc_num_l-1):
  - The sum is presented on data_out_i/q with out_valid.
  - The write-back is suppressed.
  - With acc_num_l = 1 the output is the sign-extended input.
- Addition is modular at LEN bits. No saturation is needed: with the LEN constraint, the 255 × 2^(IN_W-1) worst case fits.
- Each chirp is exactly NBIN valid samples, and the next chirp_start follows bin NBIN-1.
- Sample after bin NBIN-1 without chirp_start: dropped and frame_err set.
- chirp_start before bin NBIN-1 (short chirp): frame_err set. That sample restarts integration as chirp 0, bin 0, and acc_num is re-latched.
- chirp_start after the final chirp's bin NBIN-1: starts a new integration at chirp 0.
- Gaps in in_valid are allowed anywhere. Counters hold while in_valid=0.

## Timing
- Reset values: data_out_i/q = 0, out_valid = 0, out_last = 0, frame_err = 0, state = IDLE, all counters 0. Buffer contents are not reset.
- Pipeline, for an accepted sample at edge t:
  - S1: address and sample are registered and the buffer read is issued. Read is registered, 1 cycle.
  - S2 (edge t+1): add.
  - Edge t+2: write-back and output register update.
- Latency from in_valid to out_valid is 2 cycles. Throughput is 1 sample per clk. No backpressure.
- Read/write hazard: S2 writes bin b while S1 reads bin b+1. Addresses differ for NBIN ≥ 4, so no forwarding is required.
- Back-to-back chirps: bin 0 is read while bin NBIN-1 is being written. These are different addresses and must be legal.
- Reset asserted mid-integration: everything clears immediately. The state returns to IDLE and in-flight pipeline samples are discarded with no out_valid.

## Structure
- Shared package `radar_pkg`: IN_W/LEN/NBIN defaults, state enumeration IDLE/ACCUM, and the sign-extension helper.
- Sub-module `accum_ram`:
  - Simple dual-port, NBIN × 2·LEN, one write port and one registered read port, no reset, infers block RAM.
  - Holds I and Q concatenated in one word.
- Counters, FSM, adders and output registers live in the top module.

## Test plan
All scenarios use NBIN=8.
- acc_num=4, data_i=bin index, data_q=−bin index for all 4 chirps, back-to-back -> during chirp 3, 8 out_valid pulses. data_out_i=4·b, data_out_q=−4·b. out_last on b=7. First out_valid 2 cycles after chirp 3 bin 0.
- acc_num=0, data_i=0x7FFF -> every sample is output one-to-one with data_out_i=0x00007FFF. No out_valid on any other chirp.
- acc_num=255, data_i=0x8000 constant -> final data_out_i=0xFF808000 (−255·32768). No wrap.
- Random in_valid gaps (50% duty), acc_num=3 -> sums identical to the gapless reference model. out_valid count = 8 per integration.
- chirp_start at bin 5 of chirp 1 -> frame_err=1 and stays 1. Integration restarts. The following 3 clean chirps produce correct sums.
- rst_n pulsed low during the final chirp at bin 3 -> all outputs 0 next cycle. No out_valid until a new full integration completes.
